// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit accumulation, vend dispense and spaced change/refund pulses
module vend_credit_ctrl #(
    parameter int PRICE      = 125,
    parameter int MAX_CREDIT = 250,
    parameter int CREDIT_W   = 9,
    parameter int CHG_GAP    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                n_s,
    input  logic                di_s,
    input  logic                q_s,
    input  logic                do_s,
    input  logic                vend_req,
    input  logic                coin_ret,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                chg_n,
    output logic                chg_d,
    output logic                chg_q,
    output logic                coin_reject,
    output logic                busy
);
    typedef enum logic {IDLE, CHANGE} state_t;
    localparam logic [CREDIT_W:0]   S5      = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0]   S10     = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   S25     = (CREDIT_W+1)'(25);
    localparam logic [CREDIT_W:0]   S100    = (CREDIT_W+1)'(100);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);
    localparam logic [3:0]          GAP_C   = 4'(CHG_GAP);
    state_t              state;
    logic [3:0]          gap;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   total;
    logic                any_coin;
    logic                can_vend;
    always_comb begin
        sum      = (n_s ? S5 : '0) + (di_s ? S10 : '0) + (q_s ? S25 : '0) + (do_s ? S100 : '0);
        total    = {1'b0, credit} + sum;
        any_coin = n_s | di_s | q_s | do_s;
        can_vend = vend_req && credit >= PRICE_C;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            gap         <= '0;
            dispense    <= 1'b0;
            chg_n       <= 1'b0;
            chg_d       <= 1'b0;
            chg_q       <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            chg_n       <= 1'b0;
            chg_d       <= 1'b0;
            chg_q       <= 1'b0;
            coin_reject <= 1'b0;
            if (state == IDLE) begin
                if (can_vend) begin
                    dispense    <= 1'b1;
                    credit      <= credit - PRICE_C;
                    coin_reject <= any_coin;
                    gap         <= '0;
                    state       <= (credit != PRICE_C) ? CHANGE : IDLE;
                    busy        <= credit != PRICE_C;
                end else if (coin_ret && !vend_req && credit != '0) begin
                    state       <= CHANGE;
                    busy        <= 1'b1;
                    gap         <= '0;
                    coin_reject <= any_coin;
                end else if (total > MAX_C) begin
                    coin_reject <= 1'b1;
                end else begin
                    credit <= total[CREDIT_W-1:0];
                end
            end else begin
                coin_reject <= any_coin;
                // Empty credit ends the refund before any gap countdown is honoured
                if (credit == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (gap != '0) begin
                    gap <= gap - 4'd1;
                end else begin
                    gap <= GAP_C;
                    if (credit >= C25) begin
                        chg_q  <= 1'b1;
                        credit <= credit - C25;
                    end else if (credit >= C10) begin
                        chg_d  <= 1'b1;
                        credit <= credit - C10;
                    end else if (credit >= C5) begin
                        chg_n  <= 1'b1;
                        credit <= credit - C5;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed vector table plus hand sequences for change spacing and reset abort
module tb_vend_credit_ctrl;
    logic       clk, rst_n, n_s, di_s, q_s, do_s, vend_req, coin_ret;
    logic [8:0] credit;
    logic       dispense, chg_n, chg_d, chg_q, coin_reject, busy;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [3:0] coins;
        logic       v;
        logic       r;
        logic [8:0] cr;
        logic [5:0] o;
    } vec_t;
    vec_t vecs[$];

    vend_credit_ctrl #(.PRICE(125), .MAX_CREDIT(250), .CREDIT_W(9), .CHG_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .n_s(n_s), .di_s(di_s), .q_s(q_s), .do_s(do_s),
        .vend_req(vend_req), .coin_ret(coin_ret), .credit(credit), .dispense(dispense),
        .chg_n(chg_n), .chg_d(chg_d), .chg_q(chg_q), .coin_reject(coin_reject), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {dispense, chg_q, chg_d, chg_n, coin_reject, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic v, input logic r, input int cr, input logic [5:0] o);
        vecs.push_back('{c, v, r, 9'(cr), o});
    endtask

    // coins = {n,di,q,do}; one clock edge happens between drive and the next negedge
    task automatic cyc(input logic [3:0] c, input logic v, input logic r);
        {n_s, di_s, q_s, do_s} = c;
        vend_req = v;
        coin_ret = r;
        @(negedge clk);
    endtask

    initial begin
        int last, pulses;
        int exp_cr[3] = '{50, 25, 0};
        // outputs o = {dispense, chg_q, chg_d, chg_n, coin_reject, busy}
        add(4'b0001, 0, 0, 100, 6'b000000);
        add(4'b0010, 0, 0, 125, 6'b000000);
        add(4'b0000, 1, 0,   0, 6'b100000);
        add(4'b0000, 0, 0,   0, 6'b000000);
        add(4'b1010, 0, 0,  30, 6'b000000);
        add(4'b0001, 0, 0, 130, 6'b000000);
        add(4'b1110, 0, 0, 170, 6'b000000);
        add(4'b1010, 0, 0, 200, 6'b000000);
        add(4'b0001, 0, 0, 200, 6'b000010);
        add(4'b1111, 0, 0, 200, 6'b000010);
        add(4'b0000, 1, 0,  75, 6'b100001);
        add(4'b0000, 0, 0,  50, 6'b010001);
        add(4'b0010, 0, 0,  50, 6'b000011);
        add(4'b0000, 1, 1,  50, 6'b000001);
        add(4'b0000, 0, 0,  25, 6'b010001);
        add(4'b0000, 0, 0,  25, 6'b000001);
        add(4'b0000, 0, 0,  25, 6'b000001);
        add(4'b0000, 0, 0,   0, 6'b010001);
        add(4'b0000, 0, 0,   0, 6'b000000);
        add(4'b0010, 0, 0,  25, 6'b000000);
        add(4'b0100, 0, 0,  35, 6'b000000);
        add(4'b1000, 0, 0,  40, 6'b000000);
        add(4'b0000, 0, 1,  40, 6'b000001);
        add(4'b0000, 0, 0,  15, 6'b010001);
        add(4'b0000, 0, 0,  15, 6'b000001);
        add(4'b0000, 0, 0,  15, 6'b000001);
        add(4'b0000, 0, 0,   5, 6'b001001);
        add(4'b0000, 0, 0,   5, 6'b000001);
        add(4'b0000, 0, 0,   5, 6'b000001);
        add(4'b0000, 0, 0,   0, 6'b000101);
        add(4'b0000, 0, 0,   0, 6'b000000);
        add(4'b0001, 0, 0, 100, 6'b000000);
        add(4'b0100, 0, 0, 110, 6'b000000);
        add(4'b0100, 0, 0, 120, 6'b000000);
        add(4'b0000, 1, 0, 120, 6'b000000);
        add(4'b1000, 1, 0, 125, 6'b000000);
        add(4'b0000, 1, 0,   0, 6'b100000);
        add(4'b0000, 0, 1,   0, 6'b000000);
        add(4'b0010, 0, 0,  25, 6'b000000);
        add(4'b0100, 0, 1,  25, 6'b000011);
        add(4'b0000, 0, 0,   0, 6'b010001);
        add(4'b0000, 0, 0,   0, 6'b000000);
        add(4'b0001, 0, 0, 100, 6'b000000);
        add(4'b0010, 0, 0, 125, 6'b000000);
        add(4'b1000, 1, 0,   0, 6'b100010);
        add(4'b0001, 0, 0, 100, 6'b000000);
        add(4'b0010, 0, 0, 125, 6'b000000);
        add(4'b0000, 1, 1,   0, 6'b100000);

        rst_n = 1'b0;
        {n_s, di_s, q_s, do_s, vend_req, coin_ret} = '0;
        #1;
        chk("reset", {23'd0, credit, outs()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].coins, vecs[i].v, vecs[i].r);
            chk($sformatf("vec%0d", i), {17'd0, credit, outs()}, {17'd0, vecs[i].cr, vecs[i].o});
        end

        // two dollars, vend, then three quarters spaced CHG_GAP+1 cycles apart
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0000, 1, 0);
        chk("t2_vend", {22'd0, dispense, credit}, {22'd0, 1'b1, 9'd75});
        last = -1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(4'b0000, 0, 0);
            if (chg_d || chg_n) chk("t2_no_dn", {30'd0, chg_d, chg_n}, 32'd0);
            if (chg_q) begin
                if (pulses < 3) chk($sformatf("t2_credit%0d", pulses), 32'(credit), 32'(exp_cr[pulses]));
                if (last >= 0) chk($sformatf("t2_space%0d", pulses), 32'(c - last), 32'd3);
                last = c;
                pulses++;
            end
            if (!busy) break;
        end
        chk("t2_pulses", 32'(pulses), 32'd3);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // reset mid-change at credit 50 aborts everything
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0000, 1, 0);
        pulses = 0;
        for (int c = 0; c < 10 && !chg_q; c++) cyc(4'b0000, 0, 0);
        chk("t6_at50", {22'd0, chg_q, credit}, {22'd0, 1'b1, 9'd50});
        #2 rst_n = 1'b0;
        #1 chk("t6_async", {23'd0, credit, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc(4'b0000, 0, 0);
            if (outs() != 6'd0 || credit != 9'd0) pulses++;
        end
        chk("t6_quiet", 32'(pulses), 32'd0);
        cyc(4'b0010, 0, 0);
        chk("t6_newcoin", {17'd0, credit, outs()}, {17'd0, 9'd25, 6'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
